// File: rtl/mult_pkg.sv
// Definitions shared by the multiplier's bit-serial link blocks.
// Holds the receiver FSM state encodings and the default product width.
package mult_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RECV  = 2'b01;
   localparam logic [1:0] ST_DRAIN = 2'b10;

   localparam int MULT_Z_W = 24;

endpackage

// File: rtl/shift_in.sv
// Serial-to-parallel receiver for the framed LSB-first bit-serial link.
// Optional frame checking (frame_err) is compiled in with SHIFT_IN_FRAME_CHECK_EN.
//
// Interface timing: z_in is sampled only on edges where fz_in=1.
// z_parallel and z_valid are both updated on the edge that samples the last
// bit, so z_valid is high exactly while the new word first appears.
// There is no back-pressure: the consumer must take the word on the z_valid cycle
// or read the held z_parallel later.
module shift_in
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_Z_W,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             z_in,
   input  logic             fz_in,
   output logic [WIDTH-1:0] z_parallel,
   output logic             z_valid,
   output logic             busy,
   output logic             frame_err,
   output logic [1:0]       state_dbg
);

`ifdef SHIFT_IN_FRAME_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-2:0] shift_reg, shift_nxt;
   logic [WIDTH-1:0] par_nxt;
   logic             valid_nxt;
   logic             err_r, err_nxt;
   logic             err_done, err_done_nxt;
   logic [WIDTH-1:0] cat;
   logic             last_bit;

   // The top bit of a word never needs storage: it arrives with the load.
   assign cat      = {z_in, shift_reg};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      shift_nxt    = shift_reg;
      par_nxt      = z_parallel;
      valid_nxt    = 1'b0;
      err_nxt      = 1'b0;
      err_done_nxt = err_done;
      case (state)
         ST_IDLE: begin
            err_done_nxt = 1'b0;
            if (fz_in) begin
               shift_nxt = cat[WIDTH-1:1];
               cnt_nxt   = CNT_W'(1);
               state_nxt = ST_RECV;
            end
         end
         ST_RECV: begin
            if (fz_in) begin
               shift_nxt = cat[WIDTH-1:1];
               if (last_bit) begin
                  par_nxt   = cat;
                  valid_nxt = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = ST_DRAIN;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               cnt_nxt   = '0;
               err_nxt   = CHECK_EN;
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!fz_in) begin
               state_nxt = ST_IDLE;
            end else if (!err_done) begin
               err_nxt      = CHECK_EN;
               err_done_nxt = 1'b1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         shift_reg  <= '0;
         z_parallel <= '0;
         z_valid    <= 1'b0;
         err_r      <= 1'b0;
         err_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         shift_reg  <= shift_nxt;
         z_parallel <= par_nxt;
         z_valid    <= valid_nxt;
         err_r      <= err_nxt;
         err_done   <= err_done_nxt;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign frame_err = err_r;
   assign state_dbg = state;

endmodule

// File: tb/tb_shift_in.sv
// Self-checking bench for shift_in: directed scenarios plus random frames,
// compared against a bit-queue model of the framing rules.
module tb_shift_in;
   import mult_pkg::*;

   localparam int W = 24;
`ifdef SHIFT_IN_FRAME_CHECK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, z_in, fz_in;
   logic [W-1:0] z_parallel;
   logic         z_valid, busy, frame_err;
   logic [1:0]   state_dbg;

   int checks = 0;
   int errors = 0;
   int valid_cnt, err_cnt;

   // Reference model state: expectations after the next active edge
   logic [W-1:0] exp_par;
   logic         exp_valid, exp_err, exp_busy;
   logic         bits_q[$];
   bit           in_frame, err_given;
   logic [W-1:0] exp_q[$];

   shift_in #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .z_in(z_in), .fz_in(fz_in),
      .z_parallel(z_parallel), .z_valid(z_valid), .busy(busy),
      .frame_err(frame_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      exp_par = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
      bits_q.delete(); in_frame = 1'b0; err_given = 1'b0;
   endfunction

   function automatic void model_step(input logic z, input logic f);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (f) begin
         if (!in_frame) begin
            in_frame = 1'b1; bits_q.delete(); err_given = 1'b0;
         end
         if (bits_q.size() < W) begin
            bits_q.push_back(z);
            if (bits_q.size() == W) begin
               for (int i = 0; i < W; i++) exp_par[i] = bits_q[i];
               exp_valid = 1'b1;
               exp_q.push_back(exp_par);
            end
         end else if (!err_given) begin
            exp_err = EN; err_given = 1'b1;
         end
      end else begin
         if (in_frame && bits_q.size() < W) exp_err = EN;
         in_frame = 1'b0;
      end
      exp_busy = in_frame;
   endfunction

   // Drive one cycle's inputs; returns just after the sampling edge
   task automatic step(input logic z, input logic f);
      @(negedge clk);
      z_in = z; fz_in = f;
      model_step(z, f);
      @(posedge clk);
      #1;
   endtask

   // nbits data bits, then extra trailing bits with fz_in high, then gap idle cycles
   task automatic send_frame(input logic [W-1:0] word, input int nbits, input int extra,
                             input int gap);
      logic [W-1:0] got;
      for (int i = 0; i < nbits + extra + gap; i++) begin
         if (i < nbits) step(word[i], 1'b1);
         else if (i < nbits + extra) step(1'($urandom), 1'b1);
         else step(1'b0, 1'b0);
         checks++;
         if (z_parallel !== exp_par || z_valid !== exp_valid || busy !== exp_busy ||
             frame_err !== exp_err) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t par=%h/%h valid=%b/%b busy=%b/%b err=%b/%b",
                     $time, z_parallel, exp_par, z_valid, exp_valid, busy, exp_busy,
                     frame_err, exp_err);
         end
         valid_cnt += int'(z_valid === 1'b1);
         err_cnt   += int'(frame_err === 1'b1);
         if (z_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_unexpected got=%h required=none", z_parallel);
            end else begin
               got = exp_q.pop_front();
               if (z_parallel !== got) begin
                  errors++;
                  $display("FAIL scoreboard_word got=%h required=%h", z_parallel, got);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         z_in = 1'($urandom); fz_in = 1'($urandom);
         @(posedge clk); #1;
         checks++;
         if (z_parallel !== '0 || z_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 ||
             state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_hold par=%h valid=%b busy=%b err=%b state=%b required all 0",
                     z_parallel, z_valid, busy, frame_err, state_dbg);
         end
      end
      @(negedge clk);
      fz_in = 1'b0; z_in = 1'b0; reset = 1'b1;
      step(1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_release busy=%b state=%b required 0/%b", busy, state_dbg, ST_IDLE);
      end
   endtask

   task automatic test_nominal();
      valid_cnt = 0; err_cnt = 0;
      send_frame(24'hA5C3F1, W, 0, 1);
      checks++;
      if (z_parallel !== 24'hA5C3F1 || valid_cnt != 1 || err_cnt != 0) begin
         errors++;
         $display("FAIL nominal par=%h valid_pulses=%0d err_pulses=%0d required a5c3f1/1/0",
                  z_parallel, valid_cnt, err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      valid_cnt = 0;
      send_frame(24'h000001, W, 0, 1);
      checks++;
      if (z_parallel !== 24'h000001) begin
         errors++;
         $display("FAIL b2b_first par=%h required 000001", z_parallel);
      end
      send_frame(24'h800000, W, 0, 1);
      checks++;
      if (z_parallel !== 24'h800000 || valid_cnt != 2) begin
         errors++;
         $display("FAIL b2b_second par=%h valid_pulses=%0d required 800000/2",
                  z_parallel, valid_cnt);
      end
   endtask

   task automatic test_short_frame();
      valid_cnt = 0; err_cnt = 0;
      send_frame(W'($urandom), 10, 0, 2);
      checks++;
      if (z_parallel !== 24'h800000 || valid_cnt != 0 || err_cnt != int'(EN) || busy !== 1'b0)
      begin
         errors++;
         $display("FAIL short_frame par=%h valid=%0d err=%0d busy=%b required 800000/0/%0d/0",
                  z_parallel, valid_cnt, err_cnt, busy, EN);
      end
   endtask

   task automatic test_long_frame();
      valid_cnt = 0; err_cnt = 0;
      send_frame(24'h123456, W, 3, 1);
      checks++;
      if (z_parallel !== 24'h123456 || valid_cnt != 1 || err_cnt != int'(EN)) begin
         errors++;
         $display("FAIL long_frame par=%h valid=%0d err=%0d required 123456/1/%0d",
                  z_parallel, valid_cnt, err_cnt, EN);
      end
   endtask

   task automatic test_reset_mid_frame();
      valid_cnt = 0;
      for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      exp_q.delete();
      #1;
      checks++;
      if (z_parallel !== '0 || busy !== 1'b0 || z_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_frame par=%h busy=%b valid=%b required 0/0/0",
                  z_parallel, busy, z_valid);
      end
      repeat (2) @(negedge clk);
      fz_in = 1'b0; reset = 1'b1;
      send_frame(24'hFFFFFF, W, 0, 1);
      checks++;
      if (z_parallel !== 24'hFFFFFF || valid_cnt != 1) begin
         errors++;
         $display("FAIL after_reset_frame par=%h valid=%0d required ffffff/1",
                  z_parallel, valid_cnt);
      end
   endtask

   task automatic test_random();
      int kind;
      for (int n = 0; n < 30; n++) begin
         kind = $urandom_range(0, 2);
         send_frame(W'($urandom), (kind == 0) ? $urandom_range(1, W - 1) : W,
                    (kind == 2) ? $urandom_range(1, 4) : 0, $urandom_range(1, 3));
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_drain words_missing=%0d required 0", exp_q.size());
      end
   endtask

   initial begin
      reset = 1'b0; z_in = 1'b0; fz_in = 1'b0;
      test_reset();
      test_nominal();
      test_back_to_back();
      test_short_frame();
      test_long_frame();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
